// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters and the byte-serial memory controller.
// The arbiter connects through the slave modport; the environment connects through the master modport.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_data;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_len;
    logic        d_signed;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;

    logic        flush;

    logic        mc_running;
    logic        mc_inst_flag;
    logic [31:0] mc_inst;
    logic        mc_done;
    logic [31:0] mc_data;
    logic        mc_ifetch;
    logic        mc_load;
    logic        mc_save;
    logic [31:0] mc_if_addr;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [2:0]  mc_len;
    logic        mc_signed;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_len, d_signed, flush,
               mc_running, mc_inst_flag, mc_inst, mc_done, mc_data,
        output if_gnt, if_valid, if_data, d_gnt, d_valid, d_rdata,
               mc_ifetch, mc_load, mc_save, mc_if_addr, mc_addr, mc_wdata, mc_len, mc_signed
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_len, d_signed, flush,
               mc_running, mc_inst_flag, mc_inst, mc_done, mc_data,
        input  if_gnt, if_valid, if_data, d_gnt, d_valid, d_rdata,
               mc_ifetch, mc_load, mc_save, mc_if_addr, mc_addr, mc_wdata, mc_len, mc_signed
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the byte-serial memory controller: one transaction at a time,
// data priority with a bounded fetch starvation, and squashing of flushed fetches.
module mem_arbiter #(
    parameter int unsigned StarveMax = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

    localparam logic [3:0] StarveLimit = 4'(StarveMax);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  len_q, len_d;
    logic        signed_q, signed_d;
    logic [3:0]  starve_q, starve_d;
    logic        squash_q, squash_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;

    logic        if_gnt, d_gnt;
    logic        ifetch_stb, load_stb, save_stb;
    logic        fetch_eligible, data_wins;

    // A flush cycle hides the fetch request, so a waiting load/store may go instead.
    assign fetch_eligible = bus.if_req && !bus.flush;
    assign data_wins      = bus.d_req && (!fetch_eligible || (starve_q < StarveLimit));

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        if_addr_d  = if_addr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        signed_d   = signed_q;
        starve_d   = starve_q;
        squash_d   = squash_q;
        if_data_d  = if_data_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        ifetch_stb = 1'b0;
        load_stb   = 1'b0;
        save_stb   = 1'b0;

        if (!bus.if_req) begin
            starve_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                squash_d = 1'b0;
                if (!rst && !bus.mc_running) begin
                    if (data_wins) begin
                        d_gnt    = 1'b1;
                        addr_d   = bus.d_addr;
                        wdata_d  = bus.d_wdata;
                        len_d    = bus.d_len;
                        signed_d = bus.d_signed;
                        kind_d   = bus.d_we ? KindStore : KindLoad;
                        state_d  = StIssue;
                        if (bus.if_req && (starve_q < StarveLimit)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else if (fetch_eligible) begin
                        if_gnt    = 1'b1;
                        if_addr_d = bus.if_addr;
                        kind_d    = KindFetch;
                        starve_d  = '0;
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
                ifetch_stb = (kind_q == KindFetch);
                load_stb   = (kind_q == KindLoad);
                save_stb   = (kind_q == KindStore);
                if (kind_q == KindFetch && bus.flush) begin
                    squash_d = 1'b1;
                end
                state_d = StWait;
            end
            StWait: begin
                if (kind_q == KindFetch) begin
                    if (bus.flush) begin
                        squash_d = 1'b1;
                    end
                    if (bus.mc_inst_flag) begin
                        // A fetch flushed at any point before completion delivers nothing.
                        if (!squash_q && !bus.flush) begin
                            if_data_d  = bus.mc_inst;
                            if_valid_d = 1'b1;
                        end
                        squash_d = 1'b0;
                        state_d  = StIdle;
                    end
                end else if (bus.mc_done) begin
                    d_rdata_d = (kind_q == KindStore) ? 32'd0 : bus.mc_data;
                    d_valid_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            kind_q     <= KindFetch;
            if_addr_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            signed_q   <= 1'b0;
            starve_q   <= '0;
            squash_q   <= 1'b0;
            if_data_q  <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            if_addr_q  <= if_addr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            signed_q   <= signed_d;
            starve_q   <= starve_d;
            squash_q   <= squash_d;
            if_data_q  <= if_data_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
        end
    end

    assign bus.if_gnt     = if_gnt;
    assign bus.d_gnt      = d_gnt;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_data    = if_data_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mc_ifetch  = ifetch_stb;
    assign bus.mc_load    = load_stb;
    assign bus.mc_save    = save_stb;
    assign bus.mc_if_addr = if_addr_q;
    assign bus.mc_addr    = addr_q;
    assign bus.mc_wdata   = wdata_q;
    assign bus.mc_len     = len_q;
    assign bus.mc_signed  = signed_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter and sequencer in front of the byte-serial memory controller. It accepts instruction-fetch requests from the i-cache and load/store requests from MEM. It issues exactly one transaction at a time to the controller, holds all transaction fields stable until completion, and routes the result back to the owning requester. Data has priority, with a starvation bound for fetch and a flush that squashes stale fetches.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits; range 1..15.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  combinational one-cycle accept.
- if_valid  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSB-first.
- d_len  in  3  byte count: 1, 2 or 4.
- d_signed  in  1  sign-select, passed through unchanged.
- d_gnt  out  1  combinational one-cycle accept.
- d_valid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  32  load result; 0 for stores.
- flush  in  1  drop pending and in-flight fetch.
- mc_running  in  1  controller busy.
- mc_inst_flag  in  1  fetch complete pulse.
- mc_inst  in  32  fetched word.
- mc_done  in  1  load/store complete pulse.
- mc_data  in  32  load data.
- mc_ifetch, mc_load, mc_save  out  1 each  one-cycle start strobes.
- mc_if_addr, mc_addr, mc_wdata  out  32 each  held transaction fields.
- mc_len  out  3  held transaction field.
- mc_signed  out  1  held transaction field.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT.
- **IDLE:**
  - Arbitrate only when mc_running=0.
  - Winner selection: data wins if d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX); otherwise fetch wins if if_req=1 and flush=0.
  - The winner's gnt is asserted combinationally in that cycle.
  - The winner's fields are latched into hold registers, its kind is recorded (FETCH/LOAD/STORE), and the FSM moves to ISSUE.
- **ISSUE:**
  - Exactly one of mc_ifetch/mc_load/mc_save is high for one cycle.
  - Then go to WAIT.
- **WAIT:**
  - All strobes are low.
  - mc_if_addr, mc_addr, mc_wdata, mc_len and mc_signed stay constant; they never change between ISSUE and completion.
  - Completion is mc_inst_flag for FETCH and mc_done for LOAD/STORE.
  - On completion, register the result into if_data or d_rdata, pulse the matching valid on the next cycle, and return to IDLE.
  - A completion strobe of the wrong kind is ignored.
- **starve_cnt** (4 bits):
  - Increments, saturating at STARVE_MAX, on each data grant while if_req=1.
  - Clears on a fetch grant, or in any cycle with if_req=0.
- **Flush:**
  - In IDLE, if_req is ignored in a flush cycle.
  - With FETCH in ISSUE or WAIT, a squash flag is set. The transaction still runs to mc_inst_flag, but if_valid is suppressed and if_data is unchanged.
  - The squash flag clears on return to IDLE.
  - Flush never affects data transactions.
- **Simultaneous requests:** when d_req and if_req are both high, the loser's gnt stays 0 and it keeps requesting.
- **Reset mid-operation:**
  - All outputs go to 0, the FSM goes to IDLE, and starve_cnt and the squash flag clear.
  - Any in-flight transaction is abandoned; the controller is reset by the same rst.

## Timing
- Reset values: every output is 0, including hold registers, if_data and d_rdata.
- A grant in IDLE cycle T gives the strobe in T+1; the controller is running from T+2.
- Completion strobe in cycle C gives valid at C+1, and IDLE is re-entered at C+1.
- A new grant is possible in C+1 when mc_running=0.
- Minimum turnaround is 3 cycles of arbiter overhead per transaction, excluding controller time.
- Strobes are never asserted while mc_running=1.
- At most one transaction is outstanding.

## Test plan
- **Single fetch:** if_req with if_addr=0x100; the stub returns mc_inst=0x00A00093 after 6 cycles. Required: if_gnt at T, mc_ifetch at T+1, if_valid with if_data=0x00A00093 one cycle after mc_inst_flag.
- **Collision:** d_req load (addr 0x2000, len 4) and if_req in the same cycle. Required: d_gnt=1, if_gnt=0; the fetch is granted in the IDLE after d_valid.
- **Starvation:** STARVE_MAX=4, d_req and if_req held high continuously. Required: grant order D,D,D,D,I,D,D,D,D,I.
- **Flush:** flush while the fetch of 0x104 is in WAIT. Required: no if_valid; mc_if_addr stays 0x104 until mc_inst_flag; the next fetch issues normally.
- **Store:** d_we=1, d_wdata=0xDEADBEEF, d_len=2. Required: mc_save for one cycle; mc_wdata/mc_len stable until mc_done; d_valid with d_rdata=0.
- **Reset mid-WAIT:** assert rst during a load. Required: all outputs 0 next cycle and the FSM in IDLE; a subsequent request is granted normally.
